mitchell_div_pipe: RTL and testbench
====================================

MITCHELL_DIV_PIPE -- requirements
Module: mitchell_div_pipe

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: operand pair x/y present.
REQ-004 SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-005 SHALL have port x, input, 9 bits: dividend, sign-magnitude; [8] is the sign, [7:0] the magnitude.
REQ-006 SHALL have port y, input, 9 bits: divisor, same format as x.
REQ-007 SHALL have port out_valid, output, 1 bit: result present.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-009 SHALL have port q, output, 17 bits: quotient; [16] is the sign, [15:0] the magnitude in unsigned Q8.8.
REQ-010 SHALL have port dbz, output, 1 bit: divide-by-zero flag, qualified by out_valid.

Function
REQ-011 SHALL compute for each magnitude M (A = x[7:0], B = y[7:0]):
- k = index of the leading one, 3 bits.
- f = (M << (7-k))[6:0], 7 bits.
REQ-012 SHALL form L = {k_A,f_A} - {k_B,f_B} as an 11-bit two's-complement value in units of 2^-7 (range -1023..+1023, no overflow).
REQ-013 SHALL split L into:
- integer e = L[10:7], signed, -8..7;
- fraction g = L[6:0]; the borrow case f_A < f_B falls out of the two's-complement floor.
REQ-014 SHALL produce magnitude = (128+g) * 2^(e+1):
- left shift when e+1 >= 0;
- right shift with truncation when e+1 < 0;
- result fits 16 bits without saturation.
REQ-015 A = 0 with B != 0 SHALL give q = 17'h00000 and dbz = 0; the sign is forced to 0, and -0 counts as zero.
REQ-016 B = 0 (including A = 0) SHALL give dbz = 1 and q = 17'h0FFFF.
REQ-017 Otherwise the sign SHALL be q[16] = x[8] ^ y[8].
REQ-018 SHALL be a 3-stage pipeline:
- S1: leading-one detection, encode and normalise both operands, plus zero flags.
- S2: subtract to form L, resolve sign and zero/dbz.
- S3: antilog shift; S3 registers drive q, dbz and out_valid.
REQ-019 Latency SHALL be 3 cycles from an accepted input (in_valid & in_ready) to out_valid, when unstalled.
REQ-020 Advance SHALL be governed by a global enable en = ~out_valid | out_ready:
- in_ready = en;
- all stage registers and their valid bits load only when en = 1.
REQ-021 Pipeline occupancy:
- bubbles SHALL NOT be collapsed;
- throughput is 1 result per cycle while out_ready = 1.
REQ-022 While out_valid = 1 and out_ready = 0, q and dbz SHALL hold stable.
REQ-023 Results SHALL emerge in acceptance order; none is dropped or duplicated under any in_valid/out_ready pattern.
REQ-024 When a result is consumed and a new pair is accepted in the same cycle, both SHALL complete.

Reset
REQ-025 rst_n low SHALL asynchronously clear all stage valid bits, out_valid, q (to 0) and dbz (to 0); in-flight data is discarded.
REQ-026 After rst_n deasserts, in_ready SHALL be 1 and the first result SHALL appear 3 cycles after the first accepted pair.
REQ-027 Datapath registers other than the S3 outputs need no reset.

Structure
REQ-028 Package mitchell_pkg SHALL hold the shared constants:
- MAG_W = 8, K_W = 3, FRAC_W = 7;
- L_W = 11, Q_W = 16, STAGES = 3.
REQ-029 Sub-module mitchell_log_enc SHALL perform leading-one detection, the k encoder, normalisation and the zero flag, instantiated once per operand in S1.

Verification
REQ-030 Nominal division: x = 9'h064 (100), y = 9'h00A (10) -> L = 424, q = 17'h00A80 (10.5), dbz = 0, 3 cycles after acceptance.
REQ-031 Sign and borrow:
- x = 9'h107 (-7), y = 9'h002 -> q = 17'h10380 (3.5).
- x = 9'h008, y = 9'h003 (f_A < f_B) -> q = 17'h00300.
REQ-032 Extremes:
- x = 9'h001, y = 9'h0FF -> L = -1023, e = -8, g = 1, q = 17'h00001.
- x = 9'h0FF, y = 9'h001 -> q = 17'h0FF00.
REQ-033 Zero cases:
- y = 9'h105 over 9'h000 -> q = 17'h00000, dbz = 0.
- y = 9'h000 -> dbz = 1, q = 17'h0FFFF.
- x = 9'h100 (-0) -> treated as zero.
REQ-034 Backpressure: stream 5 pairs with out_ready = 0 -> in_ready drops to 0 once out_valid rises; q is stable; releasing out_ready delivers all 5 in order, with no loss.
REQ-035 Reset mid-operation: assert rst_n low with 3 results in flight -> out_valid = 0 and q = 0 immediately; no stale result after release.

Source files
------------

// File: rtl/mitchell_pkg.sv
// Shared widths and stage payload types for the Mitchell log-domain divider.
package mitchell_pkg;
  localparam int MAG_W  = 8;
  localparam int K_W    = 3;
  localparam int FRAC_W = 7;
  localparam int LOG_W  = K_W + FRAC_W;
  localparam int L_W    = 11;
  localparam int Q_W    = 16;
  localparam int STAGES = 3;

  typedef struct packed {
    logic [LOG_W-1:0] la;
    logic [LOG_W-1:0] lb;
    logic             za;
    logic             zb;
    logic             sign;
  } s1_t;

  typedef struct packed {
    logic [L_W-1:0] l;
    logic           dbz;
    logic           zero;
    logic           sign;
  } s2_t;
endpackage

// File: rtl/mitchell_log_enc.sv
// Mitchell log encoder: leading-one index k, normalised fraction f, zero flag.
// Purely combinational; no flow control of its own.
module mitchell_log_enc
  import mitchell_pkg::*;
(
  input  logic [MAG_W-1:0]  mag,
  output logic [K_W-1:0]    k,
  output logic [FRAC_W-1:0] f,
  output logic              zero
);

  always_comb begin
    k = '0;
    for (int i = 0; i < MAG_W; i++) begin
      if (mag[i]) k = i[K_W-1:0];
    end
  end

  // Shift the leading one into bit 7; the bits below it are the fraction.
  assign f    = FRAC_W'(mag << (3'd7 - k));
  assign zero = (mag == '0);

endmodule

// File: rtl/mitchell_div_pipe.sv
// Sign-magnitude divider using Mitchell's log approximation, Q8.8 quotient.
// Latency 3 cycles; one global enable stalls every stage while the output is held.
// Backpressure: in_ready = ~out_valid | out_ready; bubbles are not collapsed.
module mitchell_div_pipe
  import mitchell_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  x,
  input  logic [8:0]  y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] q,
  output logic        dbz
);

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // S1: log-encode both operands
  logic [K_W-1:0]    ka, kb;
  logic [FRAC_W-1:0] fa, fb;
  logic              za, zb;

  mitchell_log_enc u_enc_a (.mag(x[MAG_W-1:0]), .k(ka), .f(fa), .zero(za));
  mitchell_log_enc u_enc_b (.mag(y[MAG_W-1:0]), .k(kb), .f(fb), .zero(zb));

  s1_t  s1_nxt, s1;
  logic s1_vld;

  always_comb begin
    s1_nxt.la   = {ka, fa};
    s1_nxt.lb   = {kb, fb};
    s1_nxt.za   = za;
    s1_nxt.zb   = zb;
    s1_nxt.sign = x[8] ^ y[8];
  end

  // S2: log-domain subtract and zero/dbz resolution
  s2_t  s2_nxt, s2;
  logic s2_vld;

  always_comb begin
    s2_nxt.l    = {1'b0, s1.la} - {1'b0, s1.lb};
    s2_nxt.dbz  = s1.zb;
    s2_nxt.zero = s1.za & ~s1.zb;
    s2_nxt.sign = s1.sign & ~s1.za & ~s1.zb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else if (en) begin
      s1_vld <= in_valid;
      s2_vld <= s1_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      s1 <= s1_nxt;
      s2 <= s2_nxt;
    end
  end

  // S3: (128+g)*2^(e+1) == ({1,g} << 8) >> (7-e); 7-e spans 0..15 in 4-bit arithmetic.
  logic [3:0]     sh;
  logic [Q_W-1:0] mant, antilog;

  assign sh      = 4'd7 - s2.l[L_W-1:FRAC_W];
  assign mant    = {1'b1, s2.l[FRAC_W-1:0], 8'h00};
  assign antilog = mant >> sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      q         <= '0;
      dbz       <= 1'b0;
    end else if (en) begin
      out_valid <= s2_vld;
      if (s2_vld) begin
        dbz <= s2.dbz;
        if (s2.dbz)       q <= {1'b0, {Q_W{1'b1}}};
        else if (s2.zero) q <= '0;
        else              q <= {s2.sign, antilog};
      end
    end
  end

endmodule

// File: tb/tb_mitchell_div_pipe.sv
// Scoreboard bench for mitchell_div_pipe: directed vectors, backpressure, random stalls, reset.
module tb_mitchell_div_pipe;
  import mitchell_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, dbz;
  logic [8:0]  x, y;
  logic [16:0] q;

  int          checks = 0;
  int          errors = 0;
  int          delivered = 0;
  int          cycle = 0;
  logic [17:0] exp_q[$];
  logic        hold_vld = 1'b0;
  logic [17:0] hold_val;
  bit          rand_bp = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  mitchell_div_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready), .q(q), .dbz(dbz)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: {dbz, q} straight from the log/antilog definition in integers.
  function automatic logic [17:0] model(input logic [8:0] a, input logic [8:0] b);
    int ma, mb, ka, kb, la, lb, l, e, g, m;
    ma = int'(a[7:0]);
    mb = int'(b[7:0]);
    if (mb == 0) return {1'b1, 17'h0FFFF};
    if (ma == 0) return 18'h0;
    ka = 0;
    while ((ma >> (ka + 1)) != 0) ka++;
    kb = 0;
    while ((mb >> (kb + 1)) != 0) kb++;
    la = ka * 128 + ((ma * 128) >> ka) - 128;
    lb = kb * 128 + ((mb * 128) >> kb) - 128;
    l  = la - lb;
    e  = l >>> 7;
    g  = l - e * 128;
    if (e + 1 >= 0) m = (128 + g) << (e + 1);
    else            m = (128 + g) >> (-(e + 1));
    return {1'b0, a[8] ^ b[8], m[15:0]};
  endfunction

  // Monitor: negedge sampling; pops on handshake, checks hold stability, pushes on acceptance.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      hold_vld = 1'b0;
    end else begin
      if (out_valid) begin
        if (hold_vld) check("hold_stable", 32'({dbz, q}), 32'(hold_val));
        if (out_ready) begin
          check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            check("sb_result", 32'({dbz, q}), 32'(exp_q.pop_front()));
            delivered++;
          end
          hold_vld = 1'b0;
        end else begin
          hold_vld = 1'b1;
          hold_val = {dbz, q};
        end
      end else begin
        hold_vld = 1'b0;
      end
      if (in_valid && in_ready) exp_q.push_back(model(x, y));
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [8:0] a, input logic [8:0] b);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1; x = a; y = b;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic run_one(input string tag, input logic [8:0] a, input logic [8:0] b,
                         input logic [16:0] eq, input logic ed);
    int cyc;
    out_ready = 1'b1;
    in_valid = 1'b1; x = a; y = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(STAGES));
    check({tag, "_q"},   32'(q),   32'(eq));
    check({tag, "_dbz"}, 32'(dbz), 32'(ed));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int   t0, d0, seen;
    logic [7:0] ma, mb;

    rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_q",         32'(q),         32'd0);
    check("rst_dbz",       32'(dbz),       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    run_one("nominal",   9'h064, 9'h00A, 17'h00A80, 1'b0);
    run_one("neg_sign",  9'h107, 9'h002, 17'h10380, 1'b0);
    run_one("borrow",    9'h008, 9'h003, 17'h00300, 1'b0);
    run_one("min",       9'h001, 9'h0FF, 17'h00001, 1'b0);
    run_one("max",       9'h0FF, 9'h001, 17'h0FF00, 1'b0);
    run_one("zero_num",  9'h000, 9'h105, 17'h00000, 1'b0);
    run_one("negz_num",  9'h100, 9'h005, 17'h00000, 1'b0);
    run_one("dbz",       9'h005, 9'h000, 17'h0FFFF, 1'b1);
    run_one("dbz_neg",   9'h107, 9'h100, 17'h0FFFF, 1'b1);
    run_one("zero_zero", 9'h000, 9'h000, 17'h0FFFF, 1'b1);

    // Back-to-back throughput with the sink always ready
    out_ready = 1'b1;
    t0 = cycle;
    for (int i = 0; i < 6; i++) send(9'(17 * i + 3), 9'(i + 1));
    check("tput_cycles", 32'(cycle - t0), 32'd6);
    drain();

    // Five pairs into a stalled sink, then release
    out_ready = 1'b0;
    d0 = delivered;
    fork
      begin
        for (int i = 0; i < 5; i++) send(9'(40 + 31 * i), 9'(3 + 2 * i));
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        check("bp_in_ready",  32'(in_ready),  32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_delivered", 32'(delivered - d0), 32'd5);

    // Random traffic with random sink stalls
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end else begin
        ma = ($urandom_range(0, 6) == 0) ? 8'h00 : 8'($urandom);
        mb = ($urandom_range(0, 6) == 0) ? 8'h00 : 8'($urandom);
        send({1'($urandom), ma}, {1'($urandom), mb});
      end
    end
    rand_bp = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with three results in flight
    out_ready = 1'b0;
    send(9'h064, 9'h00A);
    send(9'h0FF, 9'h001);
    send(9'h107, 9'h002);
    check("inflight_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_q",         32'(q),         32'd0);
    check("arst_dbz",       32'(dbz),       32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("no_stale", 32'(seen), 32'd0);
    run_one("post_rst", 9'h064, 9'h00A, 17'h00A80, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
